// File: rtl/idecoder_stage.sv
// idecoder_fifo: generic DEPTH-entry circular buffer, head readable combinationally.
// Latency: a word pushed at edge e is visible at the head after edge e.
// Backpressure: the caller must not push when full or pop when empty; flush empties it.
module idecoder_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];

  // Storage write; a flushed push never lands
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally (DEPTH is a power of two); flush beats push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// idecoder_stage: FIFO-buffered ARM32 decode with a registered valid/ready output bundle.
// Latency: push at edge e into an empty stage gives out_valid after edge e+1.
// Backpressure: in_ready = (count < DEPTH) only; output holds while out_valid & !out_ready.
module idecoder_stage #(
  parameter int DEPTH        = 4,
  parameter int BRANCH_SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [31:0]            in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [6:0]             out_opcode,
  output logic [3:0]             out_cond,
  output logic [3:0]             out_rn,
  output logic [3:0]             out_rd,
  output logic [3:0]             out_rs,
  output logic [3:0]             out_rm,
  output logic [1:0]             out_shift_op,
  output logic [4:0]             out_imm5,
  output logic [11:0]            out_imm12,
  output logic [31:0]            out_imm_branch,
  output logic                   out_en_status,
  output logic                   out_P,
  output logic                   out_U,
  output logic                   out_W,
  output logic [31:0]            out_pc,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic        illegal;
    logic [3:0]  cond;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rm;
    logic [1:0]  shift_op;
    logic [4:0]  imm5;
    logic [11:0] imm12;
    logic [31:0] imm_branch;
    logic        en_status;
    logic        p;
    logic        u;
    logic        w;
    logic [31:0] pc;
  } dec_t;

  localparam int FW = $bits(fetch_t);

  fetch_t          in_word;
  fetch_t          head;
  logic [FW-1:0]   fifo_rdata;
  logic            push;
  logic            pop;
  logic [31:0]     ins;
  logic [1:0]      form;
  logic [3:0]      ls_hi;
  logic [6:0]      opc;
  logic            ill;
  logic [31:0]     br_sext;
  logic [31:0]     br_off;
  dec_t            dec_d;
  dec_t            dec_q;

  assign in_word  = '{instr: in_instr, pc: in_pc};
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && (!out_valid || out_ready);

  idecoder_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (in_word),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (count)
  );

  assign head = fetch_t'(fifo_rdata);
  assign ins  = head.instr;

  // Data-processing operand form: immediate / register / register-shifted
  assign form    = ins[25] ? 2'b00 : (ins[4] ? 2'b11 : 2'b01);
  assign br_sext = {{8{ins[23]}}, ins[23:0]};
  assign br_off  = br_sext << BRANCH_SHIFT;

  // Opcode classification of the FIFO head; unknown encodings become a flagged NOP
  always_comb begin
    opc   = 7'b0100000;
    ill   = 1'b0;
    ls_hi = 4'b0000;
    unique case (ins[27:26])
      2'b00: begin
        if (ins[27:21] == 7'b0011001) begin
          opc = 7'b0100000;
        end else if (ins[27:21] == 7'b0001000) begin
          opc = 7'b0101010;
        end else if (ins[27:21] == 7'b0001001) begin
          opc = ins[5] ? 7'b1001011 : 7'b1001001;
        end else begin
          unique case (ins[24:21])
            4'b0100: opc = {1'b0, form, 4'b1000};
            4'b0010: opc = {1'b0, form, 4'b1001};
            4'b1010: opc = {1'b0, form, 4'b1010};
            4'b0000: opc = {1'b0, form, 4'b1011};
            4'b1100: opc = {1'b0, form, 4'b1100};
            4'b0001: opc = {1'b0, form, 4'b1101};
            4'b1101: opc = {1'b0, form, 4'b0000};
            default: ill = 1'b1;
          endcase
        end
      end
      2'b01: begin
        if (ins[20]) begin
          ls_hi = ins[25] ? 4'b1101 : ((ins[19:16] == 4'hF) ? 4'b1000 : 4'b1100);
        end else begin
          ls_hi = ins[25] ? 4'b1111 : 4'b1110;
        end
        opc = {ls_hi, ins[24], ins[23], ins[21]};
      end
      2'b10: begin
        if (ins[25]) opc = ins[24] ? 7'b1001010 : 7'b1001000;
        else         ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
  end

  assign dec_d = '{
    opcode:     opc,
    illegal:    ill,
    cond:       ins[31:28],
    rn:         ins[19:16],
    rd:         ins[15:12],
    rs:         ins[11:8],
    rm:         ins[3:0],
    shift_op:   ins[6:5],
    imm5:       ins[11:7],
    imm12:      ins[11:0],
    imm_branch: br_off,
    en_status:  ins[20],
    p:          ins[24],
    u:          ins[23],
    w:          ins[21],
    pc:         head.pc
  };

  // Output register: loads on pop, empties on consume, data held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dec_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      dec_q     <= dec_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_opcode     = dec_q.opcode;
  assign out_illegal    = dec_q.illegal;
  assign out_cond       = dec_q.cond;
  assign out_rn         = dec_q.rn;
  assign out_rd         = dec_q.rd;
  assign out_rs         = dec_q.rs;
  assign out_rm         = dec_q.rm;
  assign out_shift_op   = dec_q.shift_op;
  assign out_imm5       = dec_q.imm5;
  assign out_imm12      = dec_q.imm12;
  assign out_imm_branch = dec_q.imm_branch;
  assign out_en_status  = dec_q.en_status;
  assign out_P          = dec_q.p;
  assign out_U          = dec_q.u;
  assign out_W          = dec_q.w;
  assign out_pc         = dec_q.pc;
endmodule

// File: tb/tb_idecoder_stage.sv
// Bench for idecoder_stage: scoreboard of reference-decoded bundles plus
// scenario tasks with explicit expected values from the decode tables.
module tb_idecoder_stage;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [31:0]   in_instr = '0;
  logic [31:0]   in_pc = '0;
  logic          in_ready, out_valid;
  logic [6:0]    out_opcode;
  logic [3:0]    out_cond, out_rn, out_rd, out_rs, out_rm;
  logic [1:0]    out_shift_op;
  logic [4:0]    out_imm5;
  logic [11:0]   out_imm12;
  logic [31:0]   out_imm_branch, out_pc;
  logic          out_en_status, out_P, out_U, out_W, out_illegal;
  logic [CW-1:0] count;

  logic          d2_in_ready, d2_out_valid;
  logic [6:0]    d2_opcode;
  logic [3:0]    d2_cond, d2_rn, d2_rd, d2_rs, d2_rm;
  logic [1:0]    d2_shift_op;
  logic [4:0]    d2_imm5;
  logic [11:0]   d2_imm12;
  logic [31:0]   d2_imm_branch, d2_pc;
  logic          d2_en_status, d2_P, d2_U, d2_W, d2_illegal;
  logic [CW-1:0] d2_count;

  int checks = 0;
  int errors = 0;

  typedef logic [114:0] bundle_t;
  bundle_t sb[$];
  bundle_t obs;

  always #5 clk = ~clk;

  idecoder_stage #(.DEPTH(DEPTH), .BRANCH_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_cond(out_cond), .out_rn(out_rn), .out_rd(out_rd),
    .out_rs(out_rs), .out_rm(out_rm), .out_shift_op(out_shift_op), .out_imm5(out_imm5),
    .out_imm12(out_imm12), .out_imm_branch(out_imm_branch), .out_en_status(out_en_status),
    .out_P(out_P), .out_U(out_U), .out_W(out_W), .out_pc(out_pc),
    .out_illegal(out_illegal), .count(count)
  );

  idecoder_stage #(.DEPTH(DEPTH), .BRANCH_SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_opcode(d2_opcode), .out_cond(d2_cond), .out_rn(d2_rn), .out_rd(d2_rd),
    .out_rs(d2_rs), .out_rm(d2_rm), .out_shift_op(d2_shift_op), .out_imm5(d2_imm5),
    .out_imm12(d2_imm12), .out_imm_branch(d2_imm_branch), .out_en_status(d2_en_status),
    .out_P(d2_P), .out_U(d2_U), .out_W(d2_W), .out_pc(d2_pc),
    .out_illegal(d2_illegal), .count(d2_count)
  );

  assign obs = {out_opcode, out_illegal, out_cond, out_rn, out_rd, out_rs, out_rm,
                out_shift_op, out_imm5, out_imm12, out_imm_branch, out_en_status,
                out_P, out_U, out_W, out_pc};

  // Reference decode: returns {illegal, opcode}
  function automatic logic [7:0] ref_dec(input logic [31:0] w);
    logic [1:0] f;
    logic [3:0] lo;
    logic [3:0] hi;
    f = w[25] ? 2'b00 : {w[4], 1'b1};
    if (w[27:26] == 2'b11) return {1'b1, 7'b0100000};
    if (w[27:26] == 2'b10) begin
      if (!w[25]) return {1'b1, 7'b0100000};
      return {1'b0, 5'b10010, w[24], 1'b0};
    end
    if (w[27:26] == 2'b01) begin
      if (w[20]) hi = w[25] ? 4'b1101 : (&w[19:16] ? 4'b1000 : 4'b1100);
      else       hi = w[25] ? 4'b1111 : 4'b1110;
      return {1'b0, hi, w[24], w[23], w[21]};
    end
    if (w[27:21] == 7'b0011001) return {1'b0, 7'b0100000};
    if (w[27:21] == 7'b0001000) return {1'b0, 7'b0101010};
    if (w[27:21] == 7'b0001001) return {1'b0, 5'b10010, w[5], 1'b1};
    case (w[24:21])
      4'b0100: lo = 4'b1000;
      4'b0010: lo = 4'b1001;
      4'b1010: lo = 4'b1010;
      4'b0000: lo = 4'b1011;
      4'b1100: lo = 4'b1100;
      4'b0001: lo = 4'b1101;
      4'b1101: lo = 4'b0000;
      default: return {1'b1, 7'b0100000};
    endcase
    return {1'b0, 1'b0, f, lo};
  endfunction

  function automatic bundle_t exp_bundle(input logic [31:0] w, input logic [31:0] pc);
    logic [7:0] d;
    d = ref_dec(w);
    return {d[6:0], d[7], w[31:28], w[19:16], w[15:12], w[11:8], w[3:0], w[6:5],
            w[11:7], w[11:0], {{8{w[23]}}, w[23:0]}, w[20], w[24], w[23], w[21], pc};
  endfunction

  // Scoreboard: compare on consume, then record this cycle's accepted input
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h, scoreboard empty", obs);
        end else begin
          bundle_t e;
          e = sb.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL sb_bundle: got %h want %h", obs, e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_bundle(in_instr, in_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL reset_hold: out_valid=%b count=%0d want 0/0", out_valid, count);
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_fields: got %h want 0", obs);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'hE2811005;
    in_pc     = 32'h100;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== CW'(1)) begin
      errors++;
      $display("FAIL single_latency_e: out_valid=%b count=%0d want 0/1", out_valid, count);
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid: got %b want 1", out_valid);
    end
    checks++;
    if (out_opcode !== 7'b0001000 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL single_opcode: got %b/%b want 0001000/0", out_opcode, out_illegal);
    end
    checks++;
    if (out_rn !== 4'd1 || out_rd !== 4'd1 || out_imm12 !== 12'h005 || out_pc !== 32'h100) begin
      errors++;
      $display("FAIL single_fields: rn=%h rd=%h imm12=%h pc=%h want 1 1 005 100",
               out_rn, out_rd, out_imm12, out_pc);
    end
    idle(2);
  endtask

  task automatic test_branch_load();
    in_valid = 1'b1;
    in_instr = 32'hEAFFFFFE;
    in_pc    = 32'h200;
    step();
    in_instr = 32'hE59F0004;
    in_pc    = 32'h204;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_opcode !== 7'b1001000 || out_imm_branch !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL branch_s0: op=%b imm=%h want 1001000 FFFFFFFE", out_opcode, out_imm_branch);
    end
    checks++;
    if (d2_opcode !== 7'b1001000 || d2_imm_branch !== 32'hFFFFFFF8) begin
      errors++;
      $display("FAIL branch_s2: op=%b imm=%h want 1001000 FFFFFFF8", d2_opcode, d2_imm_branch);
    end
    step();
    checks++;
    if (out_opcode !== 7'b1000110 || out_P !== 1'b1 || out_U !== 1'b1 || out_W !== 1'b0 ||
        out_en_status !== 1'b1 || out_rn !== 4'hF) begin
      errors++;
      $display("FAIL ldr_lit: op=%b P=%b U=%b W=%b S=%b rn=%h want 1000110 1 1 0 1 F",
               out_opcode, out_P, out_U, out_W, out_en_status, out_rn);
    end
    idle(2);
  endtask

  task automatic test_decode_table();
    logic [31:0] tw [16] = '{32'hE2811005, 32'hE1A00001, 32'hE0211312, 32'hE12FFF1E,
                             32'hE12FFF3E, 32'hE3200000, 32'hE1000070, 32'hEB000010,
                             32'hE5812000, 32'hE7912003, 32'hE5912000, 32'hE2411001,
                             32'hE1510002, 32'hEC000000, 32'hE0E00000, 32'hE8000000};
    logic [7:0]  te [16] = '{8'b0_0001000, 8'b0_0010000, 8'b0_0111101, 8'b0_1001001,
                             8'b0_1001011, 8'b0_0100000, 8'b0_0101010, 8'b0_1001010,
                             8'b0_1110110, 8'b0_1101110, 8'b0_1100110, 8'b0_0001001,
                             8'b0_0011010, 8'b1_0100000, 8'b1_0100000, 8'b1_0100000};
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_instr = tw[i];
      in_pc    = 32'h1000 + 32'(i * 4);
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || {out_illegal, out_opcode} !== te[i]) begin
        errors++;
        $display("FAIL decode_%08h: valid=%b ill/op=%b want 1 %b", tw[i], out_valid,
                 {out_illegal, out_opcode}, te[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    int accepted;
    int budget;
    bundle_t held;
    accepted  = 0;
    budget    = 0;
    out_ready = 1'b0;
    while (accepted < DEPTH + 1 && budget < 40) begin
      in_valid = 1'b1;
      in_instr = 32'hE2800000 | 32'(accepted);
      in_pc    = 32'h400 + 32'(accepted * 4);
      if (in_ready) accepted++;
      step();
      budget++;
    end
    checks++;
    if (in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b count=%0d want 0/%0d", in_ready, count, DEPTH);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
      errors++;
      $display("FAIL bp_head: valid=%b pc=%h want 1 400", out_valid, out_pc);
    end
    held     = obs;
    in_instr = 32'hE3A0F0AA;
    in_pc    = 32'hBAD0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== held || count !== CW'(DEPTH)) begin
        errors++;
        $display("FAIL bp_hold: obs=%h count=%0d want %h/%0d", obs, count, held, DEPTH);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 0;
    while ((out_valid || count != '0) && budget < 50) begin
      step();
      budget++;
    end
    checks++;
    if (budget >= 50 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: cycles=%0d left=%0d want drained", budget, sb.size());
    end
    idle(1);
  endtask

  task automatic test_same_edge_flush();
    int budget;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = 32'hE0200000 | 32'(i);
      in_pc    = 32'h500 + 32'(i * 4);
      step();
    end
    checks++;
    if (count !== CW'(2)) begin
      errors++;
      $display("FAIL se_pre: count=%0d want 2", count);
    end
    out_ready = 1'b1;
    in_instr  = 32'hE0200003;
    in_pc     = 32'h50C;
    step();
    checks++;
    if (count !== CW'(2)) begin
      errors++;
      $display("FAIL se_push_pop: count=%0d want 2", count);
    end
    out_ready = 1'b0;
    budget    = 0;
    while (count != CW'(DEPTH) && budget < 20) begin
      in_instr = 32'hE0400000 | 32'(budget);
      step();
      budget++;
    end
    flush    = 1'b1;
    in_instr = 32'hE3A00ABC;
    in_pc    = 32'hDEAD;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%b want 0/0", count, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || count !== '0) begin
        errors++;
        $display("FAIL flush_dropped: valid=%b pc=%h count=%0d want empty", out_valid, out_pc, count);
      end
    end
  endtask

  task automatic test_random();
    int budget;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      in_instr  = $urandom;
      in_pc     = $urandom;
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    budget    = 0;
    while ((out_valid || count != '0) && budget < 30) begin
      step();
      budget++;
    end
    checks++;
    if (budget >= 30 || sb.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: cycles=%0d left=%0d want drained", budget, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = 32'hE2811005;
      in_pc    = 32'h600 + 32'(i * 4);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== '0 || obs !== '0) begin
      errors++;
      $display("FAIL rst_async: valid=%b count=%0d obs=%h want 0/0/0", out_valid, count, obs);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: in_ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_branch_load();
    test_decode_table();
    test_backpressure();
    test_same_edge_flush();
    test_random();
    test_reset_mid();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/idecoder_stage.md
Name: idecoder_stage

Overview:
- Registered, flow-controlled ARM32 decode stage. It succeeds the combinational instruction decoder.
- Fetched instructions enter a parametrised FIFO (DEPTH entries). The FIFO head is decoded combinationally, and the result is captured in an output register with valid/ready handshake.
- Sits between fetch and the controller/register-file stage.
- New features: back-pressure, flush, PC tagging, an illegal-instruction flag, and a configurable branch-offset scale.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >=2.
- BRANCH_SHIFT, 0, left shift applied to the sign-extended branch offset; legal values 0 or 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discards all FIFO entries and the output register.
- in_valid  in  1  fetch offers in_instr/in_pc.
- in_ready  out  1  stage accepts this cycle (count < DEPTH).
- in_instr  in  32  instruction word.
- in_pc  in  32  address of the instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  consumer accepts the bundle.
- out_opcode  out  7  internal opcode.
- out_cond  out  4  instr[31:28].
- out_rn, out_rd, out_rs, out_rm  out  4 each  instr[19:16], [15:12], [11:8], [3:0].
- out_shift_op  out  2  instr[6:5].
- out_imm5  out  5  instr[11:7].
- out_imm12  out  12  instr[11:0].
- out_imm_branch  out  32  sign-extended instr[23:0] << BRANCH_SHIFT.
- out_en_status  out  1  instr[20].
- out_P, out_U, out_W  out  1 each  instr[24], instr[23], instr[21].
- out_pc  out  32  tagged PC.
- out_illegal  out  1  undefined encoding.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, not including the output register.

Behaviour:

Reset and acceptance:
- Reset (async): FIFO empty, count=0, out_valid=0, all out_* data fields=0, in_ready=1 after reset deasserts.
- Push when in_valid & in_ready. Pop head when it moves into the output register.
- The output register loads the decoded head when the FIFO is non-empty and (!out_valid | out_ready).
- Latency: instruction pushed at edge e into an empty stage gives out_valid=1 after edge e+1.
- Total capacity is DEPTH+1. There is no in→out combinational path.

Boundary conditions:
- in_ready depends only on count; it is not a function of out_ready.
- Push and pop on the same edge leave count unchanged.
- Pointers wrap modulo DEPTH.
- Output fields hold stable while out_valid & !out_ready.
- flush (sampled at edge):
  - count=0, out_valid=0 next cycle.
  - A same-cycle push is dropped.
  - Takes priority over every other action.
- rst mid-operation behaves exactly as flush plus clearing of the data fields.

Decode, instr[27:26]=00:
- Special encodings on [27:21]:
  - 0011001 → 0100000 (NOP).
  - 0001000 → 0101010 (HALT).
  - 0001001 → 1001001 (BX) if instr[5]=0, else 1001011 (BLX).
- Otherwise, op=[24:21]:
  - ADD 0100 → low3=000; SUB 0010 → 001; CMP 1010 → 010; AND 0000 → 011; ORR 1100 → 100; EOR 0001 → 101; bit3=1.
  - MOV 1101 → low4=0000.
- Bits[5:4] select the operand form:
  - 00 immediate (instr[25]=1).
  - 01 register (instr[25]=0, instr[4]=0).
  - 11 register-shifted (instr[25]=0, instr[4]=1).
  - bit6=0.
- Examples: ADD imm 0001000; MOV register 0010000; EOR register-shifted 0111101.
- Any other op → 0100000 with out_illegal=1.

Decode, instr[27:26]=10:
- [25:24]=10 → 1001000 (B).
- [25:24]=11 → 1001010 (BL).
- instr[25]=0 → 0100000, illegal=1.

Decode, instr[27:26]=01:
- out_opcode={hi4,P,U,W}.
- L=instr[20]=1:
  - I=instr[25]=0 and rn=1111 → hi4=1000 (literal).
  - I=0, other rn → 1100.
  - I=1 → 1101.
- L=0: I=0 → 1110; I=1 → 1111.

Decode, instr[27:26]=11:
- 0100000, out_illegal=1.

out_illegal is 0 for every encoding listed above as defined.

Field outputs are raw slices regardless of class.

Test Plan:
- Reset, then push E2811005 (pc 0x100), out_ready=1 → one cycle later: out_valid=1, opcode 0001000, rn=1, rd=1, imm12=0x005, out_pc=0x100, illegal=0.
- Push EAFFFFFE with BRANCH_SHIFT=0 → opcode 1001000, imm_branch=0xFFFFFFFE. Repeat with BRANCH_SHIFT=2 → 0xFFFFFFF8.
- Push E59F0004 → opcode 1000110, P=1, U=1, W=0, en_status=1, rn=F.
- out_ready=0, push DEPTH+1 instructions → in_ready=0 with count=DEPTH. Further pushes are refused, and the output holds the first word stable. Then out_ready=1 → words drain in order, no loss or duplication.
- Same-edge push+pop at count=2 → count stays 2. flush while full with in_valid=1 → next cycle count=0, out_valid=0, pushed word absent.
- Push EC000000 and E1A00000-class E0E00000 (op 0111) → opcode 0100000, illegal=1. Assert rst mid-stream → out_valid=0, count=0 immediately (async).
